// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 codes (size in [1:0], unsigned flag in [2])
//   - FSM state type
//   - byte-lane mask constants and the size/offset -> lane mask helper
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B   = 4'b0001;
  localparam logic [3:0] MASK_HLO = 4'b0011;
  localparam logic [3:0] MASK_HHI = 4'b1100;
  localparam logic [3:0] MASK_W   = 4'b1111;

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} lsu_st_t;

  // sz is funct3[1:0]; the reserved size code yields no lanes.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_mask = MASK_B << off;
      2'b01:   lane_mask = off[1] ? MASK_HHI : MASK_HLO;
      2'b10:   lane_mask = MASK_W;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/u_lsu_align.sv
// u_lsu_align: combinational data alignment for the load/store unit.
//   st     in  1=store, 0=load
//   funct3 in  RV32I funct3
//   off    in  byte offset adr[1:0]
//   wd     in  raw store data
//   rd     in  raw SRAM read word
//   mask   out byte-lane mask for the access
//   wdata  out lane-replicated store data
//   rdata  out aligned, sign/zero-extended load data
//   err    out misaligned access or illegal funct3
module u_lsu_align
  import lsu_pkg::*;
(
  input  logic        st,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] rd,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        err
);

  logic [1:0]  sz;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign sz   = funct3[1:0];
  assign mask = lane_mask(sz, off);

  always_comb begin
    err = 1'b0;
    case (sz)
      2'b01:   err = off[0];
      2'b10:   err = (off != 2'b00);
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
    // Stores have no unsigned forms; loads only have LBU/LHU.
    if (funct3[2] && (st || sz[1])) err = 1'b1;
  end

  always_comb begin
    case (sz)
      2'b00:   wdata = {4{wd[7:0]}};
      2'b01:   wdata = {2{wd[15:0]}};
      default: wdata = wd;
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    byte_v = rd[7:0];
      2'd1:    byte_v = rd[15:8];
      2'd2:    byte_v = rd[23:16];
      default: byte_v = rd[31:24];
    endcase
  end

  assign half_v = off[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    case (funct3)
      F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
      F3_BU:   rdata = {24'd0, byte_v};
      F3_H:    rdata = {{16{half_v[15]}}, half_v};
      F3_HU:   rdata = {16'd0, half_v};
      default: rdata = rd;
    endcase
  end

endmodule

// File: rtl/u_lsu.sv
// u_lsu: load/store unit between the execute stage and the SRAM data port.
//   clk, rstn             clock, asynchronous active-low reset
//   lsu_req/st/funct3/adr/wd/rd_a  request from exe (sampled in IDLE only)
//   lsu_flush             blocks acceptance; cancels a pending write-back
//   lsu_busy/done/err     status to exe / hazard unit
//   lsu_rd_e/rd_a_o/rd_i  register-file write-back
//   dat_a/we/wd/re/rd     SRAM port (driven only during the access cycle)
module u_lsu
  import lsu_pkg::*;
#(
  parameter int SRAM_LAT = 1,
  parameter int AW       = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          lsu_req,
  input  logic          lsu_st,
  input  logic [2:0]    lsu_funct3,
  input  logic [31:0]   lsu_adr,
  input  logic [31:0]   lsu_wd,
  input  logic [4:0]    lsu_rd_a,
  input  logic          lsu_flush,
  output logic          lsu_busy,
  output logic          lsu_done,
  output logic          lsu_err,
  output logic          lsu_rd_e,
  output logic [4:0]    lsu_rd_a_o,
  output logic [31:0]   lsu_rd_i,
  output logic [AW-1:0] dat_a,
  output logic [3:0]    dat_we,
  output logic [31:0]   dat_wd,
  output logic [3:0]    dat_re,
  input  logic [31:0]   dat_rd
);

  localparam logic [2:0] LAT_M1 = 3'(SRAM_LAT - 1);

  lsu_st_t       state;
  logic [2:0]    cnt;
  logic          flushed_q;
  logic [4:0]    rd_a_q;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] adr_q;
  logic [31:0]   wd_q;

  logic          accept;
  logic          in_acc;
  logic          in_resp;
  logic          acc_ok;
  logic [3:0]    mask;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          err;
  logic          unused_adr;

  // Upper address bits alias onto the SRAM window.
  assign unused_adr = ^lsu_adr[31:AW+2];

  assign accept  = (state == IDLE) && lsu_req && !lsu_flush;
  assign in_acc  = (state == ACC);
  assign in_resp = (state == RESP);
  assign acc_ok  = in_acc && !err;

  u_lsu_align u_align (
    .st     (st_q),
    .funct3 (f3_q),
    .off    (adr_q[1:0]),
    .wd     (wd_q),
    .rd     (dat_rd),
    .mask   (mask),
    .wdata  (wdata),
    .rdata  (rdata),
    .err    (err)
  );

  // Request capture: data fields carry no reset, they are qualified by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      st_q  <= lsu_st;
      f3_q  <= lsu_funct3;
      adr_q <= lsu_adr[AW+1:0];
      wd_q  <= lsu_wd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      flushed_q <= 1'b0;
      rd_a_q    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= ACC;
            flushed_q <= 1'b0;
            rd_a_q    <= lsu_rd_a;
          end
        end
        ACC: begin
          if (st_q || err) begin
            state <= IDLE;
          end else if (SRAM_LAT > 1) begin
            state <= WAIT;
            cnt   <= LAT_M1;
          end else begin
            state <= RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if ((state != IDLE) && lsu_flush) flushed_q <= 1'b1;
    end
  end

  // Access cycle: SRAM port live only here, and only for a legal request.
  assign dat_a  = acc_ok ? adr_q[AW+1:2] : '0;
  assign dat_we = (acc_ok && st_q)  ? mask  : 4'd0;
  assign dat_wd = (acc_ok && st_q)  ? wdata : 32'd0;
  assign dat_re = (acc_ok && !st_q) ? mask  : 4'd0;

  // Completion / write-back; a flush arriving in RESP itself also cancels.
  assign lsu_busy   = (state != IDLE);
  assign lsu_done   = (in_acc && (st_q || err)) || in_resp;
  assign lsu_err    = in_acc && err;
  assign lsu_rd_e   = in_resp && !flushed_q && !lsu_flush && (rd_a_q != 5'd0);
  assign lsu_rd_i   = in_resp ? rdata : 32'd0;
  assign lsu_rd_a_o = rd_a_q;

endmodule

// File: tb/tb_u_lsu.sv
// tb_u_lsu: scoreboard bench for u_lsu with a 3-cycle SRAM latency.
module tb_u_lsu;

  localparam int LAT = 3;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rstn;
  logic        lsu_req, lsu_st, lsu_flush;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_adr, lsu_wd, dat_rd;
  logic [4:0]  lsu_rd_a;
  logic        lsu_busy, lsu_done, lsu_err, lsu_rd_e;
  logic [4:0]  lsu_rd_a_o;
  logic [31:0] lsu_rd_i, dat_wd;
  logic [15:0] dat_a;
  logic [3:0]  dat_we, dat_re;

  typedef struct {
    string       tag;
    logic        err;
    logic        ld;
    logic        rde;
    logic [4:0]  rda;
    logic [31:0] rdi;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  u_lsu #(.SRAM_LAT(LAT), .AW(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .lsu_req    (lsu_req),
    .lsu_st     (lsu_st),
    .lsu_funct3 (lsu_funct3),
    .lsu_adr    (lsu_adr),
    .lsu_wd     (lsu_wd),
    .lsu_rd_a   (lsu_rd_a),
    .lsu_flush  (lsu_flush),
    .lsu_busy   (lsu_busy),
    .lsu_done   (lsu_done),
    .lsu_err    (lsu_err),
    .lsu_rd_e   (lsu_rd_e),
    .lsu_rd_a_o (lsu_rd_a_o),
    .lsu_rd_i   (lsu_rd_i),
    .dat_a      (dat_a),
    .dat_we     (dat_we),
    .dat_wd     (dat_wd),
    .dat_re     (dat_re),
    .dat_rd     (dat_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Completion monitor: every lsu_done pops one expected result.
  always @(negedge clk) begin
    if (rstn && lsu_done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_err"},  32'(lsu_err), 32'(mon_e.err));
        chk({mon_e.tag, "_rd_e"}, 32'(lsu_rd_e), 32'(mon_e.rde));
        chk({mon_e.tag, "_rd_a"}, 32'(lsu_rd_a_o), 32'(mon_e.rda));
        chk({mon_e.tag, "_lat"},  32'(cyc - mon_e.t0), 32'(mon_e.lat));
        if (mon_e.ld) chk({mon_e.tag, "_rd_i"}, lsu_rd_i, mon_e.rdi);
      end
    end
  end

  task automatic xact(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] adr, input logic [31:0] wd, input logic [4:0] rda,
                      input logic [31:0] rdata, input logic [3:0] x_mask, input logic [31:0] x_wd,
                      input logic x_err, input logic [31:0] x_rdi, input int flush_cyc);
    exp_t        e;
    logic [31:0] x_a;
    bit          idle;
    @(posedge clk); #1;
    lsu_st = st; lsu_funct3 = f3; lsu_adr = adr; lsu_wd = wd; lsu_rd_a = rda;
    dat_rd = rdata; lsu_req = 1'b1;
    e.tag = tag; e.err = x_err; e.ld = !st && !x_err;
    e.rde = e.ld && (rda != 5'd0) && (flush_cyc < 0);
    e.rda = rda; e.rdi = x_rdi; e.t0 = cyc;
    e.lat = (st || x_err) ? 1 : 1 + LAT;
    sb.push_back(e);
    // cycle 1: access
    @(posedge clk); #1;
    lsu_req = 1'b0;
    x_a = x_err ? 32'd0 : {16'd0, adr[17:2]};
    chk({tag, "_busy"}, 32'(lsu_busy), 32'd1);
    chk({tag, "_dat_a"}, 32'(dat_a), x_a);
    chk({tag, "_dat_we"}, 32'(dat_we), (st && !x_err) ? 32'(x_mask) : 32'd0);
    chk({tag, "_dat_re"}, 32'(dat_re), (!st && !x_err) ? 32'(x_mask) : 32'd0);
    chk({tag, "_dat_wd"}, dat_wd, (st && !x_err) ? x_wd : 32'd0);
    idle = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      @(posedge clk); #1;
      lsu_flush = (c == flush_cyc);
      if (!lsu_busy) begin
        idle = 1'b1;
        break;
      end
    end
    lsu_flush = 1'b0;
    chk({tag, "_idle"}, 32'(idle), 32'd1);
    chk({tag, "_sram_off"}, {dat_we, dat_re, 24'd0}, 32'd0);
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; lsu_req = 1'b0; lsu_st = 1'b0; lsu_funct3 = 3'd0; lsu_adr = 32'd0;
    lsu_wd = 32'd0; lsu_rd_a = 5'd0; lsu_flush = 1'b0; dat_rd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    chk("rst_done_err_rde", {29'd0, lsu_done, lsu_err, lsu_rd_e}, 32'd0);
    chk("rst_rd_a_o", 32'(lsu_rd_a_o), 32'd0);
    chk("rst_sram", {dat_we, dat_re, dat_a, 8'd0}, 32'd0);
    chk("rst_dat_wd", dat_wd, 32'd0);
    chk("rst_rd_i", lsu_rd_i, 32'd0);
    rstn = 1'b1;

    // A flushed request is never accepted.
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_flush = 1'b1; lsu_st = 1'b1; lsu_funct3 = LW;
    @(posedge clk); #1;
    chk("flush_blocks", 32'(lsu_busy), 32'd0);
    lsu_req = 1'b0; lsu_flush = 1'b0;

    //   tag        st    f3      adr           wd            rda  rdata         mask     wd            err   rdi           flush
    xact("sw",      1'b1, LW,     32'h0000_0104, 32'hDEAD_BEEF, 5'd1, 32'd0,        4'b1111, 32'hDEAD_BEEF, 1'b0, 32'd0,        -1);
    xact("sb",      1'b1, LB,     32'h0000_0203, 32'h0000_00A5, 5'd1, 32'd0,        4'b1000, 32'hA5A5_A5A5, 1'b0, 32'd0,        -1);
    xact("sh",      1'b1, LH,     32'h0000_0302, 32'h1234_ABCD, 5'd1, 32'd0,        4'b1100, 32'hABCD_ABCD, 1'b0, 32'd0,        -1);
    xact("lb",      1'b0, LB,     32'h0000_0102, 32'd0,         5'd5, 32'h1280_FF34, 4'b0100, 32'd0,         1'b0, 32'hFFFF_FF80, -1);
    xact("lbu",     1'b0, LBU,    32'h0000_0102, 32'd0,         5'd5, 32'h1280_FF34, 4'b0100, 32'd0,         1'b0, 32'h0000_0080, -1);
    xact("lh_hi",   1'b0, LH,     32'h0000_0106, 32'd0,         5'd4, 32'h8001_7FFF, 4'b1100, 32'd0,         1'b0, 32'hFFFF_8001, -1);
    xact("lh_mis",  1'b0, LH,     32'h0000_0101, 32'd0,         5'd6, 32'h1111_2222, 4'b0000, 32'd0,         1'b1, 32'd0,        -1);
    xact("sw_mis",  1'b1, LW,     32'h0000_0102, 32'h5555_5555, 5'd8, 32'd0,        4'b0000, 32'd0,         1'b1, 32'd0,        -1);
    xact("st_ill",  1'b1, 3'b011, 32'h0000_0000, 32'h1234_5678, 5'd2, 32'd0,        4'b0000, 32'd0,         1'b1, 32'd0,        -1);
    xact("ld_ill",  1'b0, 3'b110, 32'h0000_0000, 32'd0,         5'd2, 32'h1234_5678, 4'b0000, 32'd0,         1'b1, 32'd0,        -1);
    xact("lw_r0",   1'b0, LW,     32'h0000_0010, 32'd0,         5'd0, 32'h0BAD_F00D, 4'b1111, 32'd0,         1'b0, 32'h0BAD_F00D, -1);
    xact("lw_flush",1'b0, LW,     32'h0000_0010, 32'd0,         5'd7, 32'h0BAD_F00D, 4'b1111, 32'd0,         1'b0, 32'h0BAD_F00D, 2);
    xact("lw_alias",1'b0, LW,     32'hFFFC_0008, 32'd0,         5'd9, 32'hCAFE_F00D, 4'b1111, 32'd0,         1'b0, 32'hCAFE_F00D, -1);

    // Reset while a load sits in WAIT: everything drops at once.
    @(posedge clk); #1;
    lsu_st = 1'b0; lsu_funct3 = LW; lsu_adr = 32'h0000_0040; lsu_rd_a = 5'd6; lsu_req = 1'b1;
    @(posedge clk); #1;
    lsu_req = 1'b0;
    @(posedge clk); #1;
    chk("wait_busy", 32'(lsu_busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(lsu_busy), 32'd0);
    chk("arst_ctl", {28'd0, lsu_done, lsu_err, lsu_rd_e, 1'b0}, 32'd0);
    chk("arst_rd_a_o", 32'(lsu_rd_a_o), 32'd0);
    chk("arst_sram", {dat_we, dat_re, dat_a, 8'd0}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    xact("lhu_post",1'b0, LHU,    32'h0000_0102, 32'd0,         5'd3, 32'h8001_1234, 4'b1100, 32'd0,         1'b0, 32'h0000_8001, -1);

    repeat (2) @(posedge clk);
    #1;
    chk("final_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
